calc_sequencer: RTL and testbench
=================================

Name: calc_sequencer

Overview:
Control FSM for the calculator datapath. It turns debounced key strobes into signed 10-bit operands and an opcode, then issues one start pulse to the external ALU and waits for its done/error handshake. It latches the result for the display scanner and owns the error flag. It sits between the key decoder and the ALU/display path.

Parameters:
DATA_W, 10, operand/result width (two's complement)
MAX_DIGITS, 3, decimal digits accepted per operand
TIMEOUT, 16, cycles allowed between alu_start and alu_done before error

Ports:
clk  in  1  system clock
reset  in  1  asynchronous, active-high reset
key_valid  in  1  one-cycle key strobe, already debounced
key_type  in  3  0=DIGIT 1=SIGN 2=OP 3=EQUALS 4=CLEAR, others ignored
key_val  in  4  digit value (DIGIT) or opcode (OP)
alu_a  out  DATA_W  operand A
alu_b  out  DATA_W  operand B
alu_op  out  3  0=ADD 1=AND 2=OR 3=XOR 4=NOT (unary, uses A)
alu_start  out  1  one-cycle request pulse
alu_done  in  1  one-cycle completion strobe
alu_result  in  DATA_W  result, valid with alu_done
alu_error  in  1  ALU overflow flag, valid with alu_done
disp_value  out  DATA_W  signed value for the display scanner
error  out  1  sticky error flag
busy  out  1  high in S_EXEC

Behaviour:
- Reset: state S_A; entry magnitude, sign and count = 0; alu_a/alu_b/alu_op/disp_value = 0; alu_start, error and busy = 0; timeout counter = 0.
- Entry: a DIGIT with key_val<=9 and count<MAX_DIGITS sets mag=mag*10+val and count++. A digit with key_val>9, or a digit beyond MAX_DIGITS, is ignored. SIGN toggles the sign. Signed value = sign ? -mag : mag, in DATA_W bits.
- Range check at commit: positive mag<=511, negative mag<=512. A failure goes to S_ERR.
- S_A:
  - OP with key_val<=4: commit the entry to alu_a, latch alu_op, clear the entry, go to S_B. Opcodes >4 are ignored.
  - OP with NOT: commits A, then goes directly to S_EXEC.
  - EQUALS: ignored.
- S_B:
  - OP with count==0: replaces alu_op. OP with count>0: ignored.
  - EQUALS: commit to alu_b, go to S_EXEC.
- S_EXEC:
  - alu_start is high for exactly the first cycle in the state. Registered output, so it is asserted the cycle after the commit key.
  - alu_done with alu_error=0: disp_value=alu_result, go to S_SHOW.
  - alu_done with alu_error=1: go to S_ERR.
  - No alu_done within TIMEOUT cycles after alu_start: go to S_ERR.
  - All keys except CLEAR are ignored.
- S_SHOW:
  - DIGIT: start a new entry with that digit, go to S_A.
  - OP: alu_a=result (chaining), latch op, go to S_B. A NOT op goes to S_EXEC instead.
  - SIGN and EQUALS: ignored.
- S_ERR: error=1 and disp_value=0. Only CLEAR exits.
- CLEAR in any state: same state as reset, next cycle. It aborts S_EXEC. A later alu_done is ignored.
- Simultaneous events:
  - CLEAR and alu_done in the same cycle: CLEAR wins.
  - Any other key in the same cycle as alu_done: the key is dropped.
- disp_value source: the signed entry in S_A/S_B (entry value, not the committed operand), the result in S_SHOW, and 0 in S_ERR.
- Reset mid-operation: all of the above returns to reset values asynchronously.

Decomposition:
- calc_pkg holds the key_type codes, the opcode constants, the state enum {S_A,S_B,S_EXEC,S_SHOW,S_ERR}, and the range limits 511/512.
- One sub-module, calc_entry, covers digit accumulation, the sign toggle, the count limit, the signed conversion and the range_ok output.

Test Plan:
- Reset; keys 1,2,3, OP ADD, 4,5, EQUALS -> single-cycle alu_start with alu_a=123, alu_b=45, alu_op=0, busy=1. Drive alu_done with result 168 -> disp_value=168, busy=0.
- Keys 9,9,9, OP ADD -> error=1, alu_start never asserted. CLEAR -> error=0, disp_value=0.
- Keys 5,1,2, SIGN, OP AND -> alu_a=10'h200 (-512) accepted. Keys 1,2,3,4 -> entry shows 123, 4th digit ignored.
- EQUALS with no alu_done for 16 cycles -> error=1 on the 17th cycle after alu_start. alu_error=1 on done -> error=1.
- In S_SHOW with result 168: OP XOR, 3, EQUALS -> alu_a=168, alu_b=3, alu_op=3.
- CLEAR during S_EXEC, then alu_done with result 77 two cycles later -> ignored: disp_value=0, state S_A, error=0.

Source files
------------

// File: rtl/calc_pkg.sv
// Shared definitions for the calculator sequencer: key codes, ALU opcodes,
// sequencer states and the signed operand range limits.
// No logic; imported by calc_entry and calc_sequencer.
package calc_pkg;

    // key_type encodings from the key decoder
    localparam logic [2:0] KEY_DIGIT  = 3'd0;
    localparam logic [2:0] KEY_SIGN   = 3'd1;
    localparam logic [2:0] KEY_OP     = 3'd2;
    localparam logic [2:0] KEY_EQUALS = 3'd3;
    localparam logic [2:0] KEY_CLEAR  = 3'd4;

    // alu_op encodings; NOT is unary and only uses operand A
    localparam logic [2:0] OP_ADD = 3'd0;
    localparam logic [2:0] OP_AND = 3'd1;
    localparam logic [2:0] OP_OR  = 3'd2;
    localparam logic [2:0] OP_XOR = 3'd3;
    localparam logic [2:0] OP_NOT = 3'd4;

    typedef enum logic [2:0] {
        S_A,
        S_B,
        S_EXEC,
        S_SHOW,
        S_ERR
    } state_e;

    // largest magnitudes representable in a 10-bit two's complement operand
    localparam int POS_LIMIT = 511;
    localparam int NEG_LIMIT = 512;

endpackage

// File: rtl/calc_entry.sv
// Operand entry: accumulates decimal digits and a sign into a signed value.
// Latency: value/range_ok reflect a key one cycle after its strobe.
// Backpressure: none; excess or out-of-range digits are silently dropped.
// Ports: clk/reset; clr (sync clear, wins over digit/sign); digit_en+digit,
//        sign_en (toggle); value (signed DATA_W), count_zero, range_ok.
module calc_entry
    import calc_pkg::*;
#(
    parameter int DATA_W     = 10,
    parameter int MAX_DIGITS = 3
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              clr,
    input  logic              digit_en,
    input  logic              sign_en,
    input  logic [3:0]        digit,
    output logic [DATA_W-1:0] value,
    output logic              count_zero,
    output logic              range_ok
);
    localparam int CNT_W = $clog2(MAX_DIGITS + 1);
    localparam logic [CNT_W-1:0]  CNT_MAX = CNT_W'(MAX_DIGITS);
    localparam logic [DATA_W-1:0] POS_LIM = DATA_W'(POS_LIMIT);
    localparam logic [DATA_W-1:0] NEG_LIM = DATA_W'(NEG_LIMIT);

    logic [DATA_W-1:0] mag_q;
    logic              sign_q;
    logic [CNT_W-1:0]  cnt_q;
    logic              accept;

    assign accept = digit_en && (digit <= 4'd9) && (cnt_q < CNT_MAX);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            mag_q  <= '0;
            sign_q <= 1'b0;
            cnt_q  <= '0;
        end else if (clr) begin
            mag_q  <= '0;
            sign_q <= 1'b0;
            cnt_q  <= '0;
        end else begin
            if (accept) begin
                // MAX_DIGITS decimal digits (999) still fit in DATA_W unsigned bits
                mag_q <= mag_q * DATA_W'(10) + DATA_W'(digit);
                cnt_q <= cnt_q + CNT_W'(1);
            end
            if (sign_en) begin
                sign_q <= ~sign_q;
            end
        end
    end

    assign value      = sign_q ? -mag_q : mag_q;
    assign count_zero = (cnt_q == '0);
    // negative side reaches one further than positive (two's complement)
    assign range_ok   = sign_q ? (mag_q <= NEG_LIM) : (mag_q <= POS_LIM);

endmodule

// File: rtl/calc_sequencer.sv
// Calculator control FSM: builds operands/opcode from keys, runs one ALU op.
// Latency: alu_start one cycle after the committing key; result shown the cycle after alu_done.
// Backpressure: none; keys outside their valid state, or coincident with alu_done, are dropped.
// Ports: clk/reset; key_valid/key_type/key_val from the key decoder;
//        alu_a/alu_b/alu_op/alu_start to the ALU, alu_done/alu_result/alu_error back;
//        disp_value to the display scanner; error (sticky until CLEAR); busy (in S_EXEC).
module calc_sequencer
    import calc_pkg::*;
#(
    parameter int DATA_W     = 10,
    parameter int MAX_DIGITS = 3,
    parameter int TIMEOUT    = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              key_valid,
    input  logic [2:0]        key_type,
    input  logic [3:0]        key_val,
    output logic [DATA_W-1:0] alu_a,
    output logic [DATA_W-1:0] alu_b,
    output logic [2:0]        alu_op,
    output logic              alu_start,
    input  logic              alu_done,
    input  logic [DATA_W-1:0] alu_result,
    input  logic              alu_error,
    output logic [DATA_W-1:0] disp_value,
    output logic              error,
    output logic              busy
);
    localparam int TMO_W = $clog2(TIMEOUT + 1);
    localparam logic [TMO_W-1:0] TMO_MAX = TMO_W'(TIMEOUT);

    state_e            state, next_state;
    logic [TMO_W-1:0]  tmo_q;
    logic [DATA_W-1:0] res_q;
    logic [DATA_W-1:0] entry_value;
    logic              entry_zero, entry_ok;

    logic is_clear, key_ok, k_digit, k_sign, k_op, k_eq;
    logic op_legal, op_unary, digit_legal;
    logic ld_a_entry, ld_a_res, ld_op, ld_b, ld_res;
    logic entry_clr, digit_en, sign_en, clr_all;

    // CLEAR is honoured even alongside alu_done; every other key loses to it
    assign is_clear    = key_valid && (key_type == KEY_CLEAR);
    assign key_ok      = key_valid && !alu_done;
    assign k_digit     = key_ok && (key_type == KEY_DIGIT);
    assign k_sign      = key_ok && (key_type == KEY_SIGN);
    assign k_op        = key_ok && (key_type == KEY_OP);
    assign k_eq        = key_ok && (key_type == KEY_EQUALS);
    assign op_legal    = (key_val <= {1'b0, OP_NOT});
    assign op_unary    = (key_val == {1'b0, OP_NOT});
    assign digit_legal = (key_val <= 4'd9);

    calc_entry #(
        .DATA_W     (DATA_W),
        .MAX_DIGITS (MAX_DIGITS)
    ) u_entry (
        .clk        (clk),
        .reset      (reset),
        .clr        (entry_clr),
        .digit_en   (digit_en),
        .sign_en    (sign_en),
        .digit      (key_val),
        .value      (entry_value),
        .count_zero (entry_zero),
        .range_ok   (entry_ok)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= S_A;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        ld_a_entry = 1'b0;
        ld_a_res   = 1'b0;
        ld_op      = 1'b0;
        ld_b       = 1'b0;
        ld_res     = 1'b0;
        entry_clr  = 1'b0;
        digit_en   = 1'b0;
        sign_en    = 1'b0;
        clr_all    = 1'b0;

        if (is_clear) begin
            next_state = S_A;
            clr_all    = 1'b1;
            entry_clr  = 1'b1;
        end else begin
            case (state)
                S_A: begin
                    digit_en = k_digit;
                    sign_en  = k_sign;
                    if (k_op && op_legal) begin
                        entry_clr = 1'b1;
                        if (!entry_ok) begin
                            next_state = S_ERR;
                        end else begin
                            ld_a_entry = 1'b1;
                            ld_op      = 1'b1;
                            next_state = op_unary ? S_EXEC : S_B;
                        end
                    end
                end
                S_B: begin
                    digit_en = k_digit;
                    sign_en  = k_sign;
                    // operator may be changed only before B has any digits
                    if (k_op && op_legal && entry_zero) begin
                        ld_op = 1'b1;
                    end
                    if (k_eq) begin
                        entry_clr = 1'b1;
                        if (!entry_ok) begin
                            next_state = S_ERR;
                        end else begin
                            ld_b       = 1'b1;
                            next_state = S_EXEC;
                        end
                    end
                end
                S_EXEC: begin
                    if (alu_done) begin
                        if (alu_error) begin
                            next_state = S_ERR;
                        end else begin
                            ld_res     = 1'b1;
                            next_state = S_SHOW;
                        end
                    end else if (tmo_q == TMO_MAX) begin
                        next_state = S_ERR;
                    end
                end
                S_SHOW: begin
                    // entry is already empty here, so the digit starts a fresh operand
                    if (k_digit && digit_legal) begin
                        digit_en   = 1'b1;
                        next_state = S_A;
                    end else if (k_op && op_legal) begin
                        ld_a_res   = 1'b1;
                        ld_op      = 1'b1;
                        next_state = op_unary ? S_EXEC : S_B;
                    end
                end
                S_ERR: begin
                    next_state = S_ERR;
                end
                default: begin
                    next_state = S_A;
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            alu_a     <= '0;
            alu_b     <= '0;
            alu_op    <= '0;
            res_q     <= '0;
            alu_start <= 1'b0;
            tmo_q     <= '0;
        end else begin
            if (clr_all) begin
                alu_a  <= '0;
                alu_b  <= '0;
                alu_op <= '0;
                res_q  <= '0;
            end else begin
                if (ld_a_entry) begin
                    alu_a <= entry_value;
                end else if (ld_a_res) begin
                    alu_a <= res_q;
                end
                if (ld_op) begin
                    alu_op <= key_val[2:0];
                end
                if (ld_b) begin
                    alu_b <= entry_value;
                end
                if (ld_res) begin
                    res_q <= alu_result;
                end
            end
            // pulse only on the transition into S_EXEC
            alu_start <= (next_state == S_EXEC) && (state != S_EXEC);
            // tmo_q counts cycles since alu_start; 0 on the start cycle itself
            tmo_q     <= ((state == S_EXEC) && (next_state == S_EXEC)) ? tmo_q + TMO_W'(1) : '0;
        end
    end

    always_comb begin
        disp_value = '0;
        case (state)
            S_A, S_B:      disp_value = entry_value;
            S_EXEC, S_SHOW: disp_value = res_q;
            default:       disp_value = '0;
        endcase
    end

    assign error = (state == S_ERR);
    assign busy  = (state == S_EXEC);

endmodule

// File: tb/tb_calc_sequencer.sv
// Directed bench for calc_sequencer: alu_start transactions are checked by a
// scoreboard monitor against expectations queued by the stimulus thread;
// steady-state outputs (display, error, busy) are checked inline.
module tb_calc_sequencer;
    import calc_pkg::*;

    logic       clk = 1'b0;
    logic       reset;
    logic       key_valid;
    logic [2:0] key_type;
    logic [3:0] key_val;
    logic [9:0] alu_a, alu_b;
    logic [2:0] alu_op;
    logic       alu_start;
    logic       alu_done;
    logic [9:0] alu_result;
    logic       alu_error;
    logic [9:0] disp_value;
    logic       error, busy;

    int errors = 0;
    int checks = 0;

    typedef struct packed {
        logic [9:0] a;
        logic [9:0] b;
        logic [2:0] op;
    } exp_t;

    exp_t exp_q[$];
    exp_t mon_e;
    logic prev_start = 1'b0;

    always #5 clk = ~clk;

    calc_sequencer #(
        .DATA_W     (10),
        .MAX_DIGITS (3),
        .TIMEOUT    (16)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .key_valid  (key_valid),
        .key_type   (key_type),
        .key_val    (key_val),
        .alu_a      (alu_a),
        .alu_b      (alu_b),
        .alu_op     (alu_op),
        .alu_start  (alu_start),
        .alu_done   (alu_done),
        .alu_result (alu_result),
        .alu_error  (alu_error),
        .disp_value (disp_value),
        .error      (error),
        .busy       (busy)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", name, act, act, req, req);
        end
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic key(input logic [2:0] t, input logic [3:0] v);
        key_valid = 1'b1;
        key_type  = t;
        key_val   = v;
        step(1);
        key_valid = 1'b0;
        key_type  = 3'd0;
        key_val   = 4'd0;
    endtask

    task automatic dig(input logic [3:0] v);
        key(KEY_DIGIT, v);
    endtask

    task automatic opkey(input logic [2:0] op);
        key(KEY_OP, {1'b0, op});
    endtask

    task automatic done(input logic [9:0] r, input logic e);
        alu_done   = 1'b1;
        alu_result = r;
        alu_error  = e;
        step(1);
        alu_done   = 1'b0;
        alu_result = 10'd0;
        alu_error  = 1'b0;
    endtask

    task automatic push(input logic [9:0] a, input logic [9:0] b, input logic [2:0] op);
        exp_t e;
        e.a  = a;
        e.b  = b;
        e.op = op;
        exp_q.push_back(e);
    endtask

    // scoreboard monitor: every alu_start must match the oldest expectation
    always begin
        @(posedge clk);
        #2;
        if (prev_start) check("start_width", 32'(alu_start), 32'd0);
        if (alu_start) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_start: got alu_start=1 a=%0d b=%0d op=%0d, expected no start",
                         alu_a, alu_b, alu_op);
            end else begin
                mon_e = exp_q.pop_front();
                check("start_a", 32'(alu_a), 32'(mon_e.a));
                check("start_b", 32'(alu_b), 32'(mon_e.b));
                check("start_op", 32'(alu_op), 32'(mon_e.op));
                check("start_busy", 32'(busy), 32'd1);
            end
        end
        prev_start = alu_start;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got no end of test, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        reset      = 1'b1;
        key_valid  = 1'b0;
        key_type   = 3'd0;
        key_val    = 4'd0;
        alu_done   = 1'b0;
        alu_result = 10'd0;
        alu_error  = 1'b0;
        step(2);
        check("rst_disp", 32'(disp_value), 32'd0);
        check("rst_error", 32'(error), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_start", 32'(alu_start), 32'd0);
        check("rst_a", 32'(alu_a), 32'd0);
        check("rst_op", 32'(alu_op), 32'd0);
        reset = 1'b0;
        step(1);

        // 123 + 45 = 168
        dig(4'd12);
        check("bad_digit_ignored", 32'(disp_value), 32'd0);
        dig(4'd1); dig(4'd2); dig(4'd3);
        check("entry_123", 32'(disp_value), 32'd123);
        opkey(OP_ADD);
        check("entry_cleared", 32'(disp_value), 32'd0);
        dig(4'd4); dig(4'd5);
        check("entry_45", 32'(disp_value), 32'd45);
        push(10'd123, 10'd45, OP_ADD);
        key(KEY_EQUALS, 4'd0);
        check("exec_busy", 32'(busy), 32'd1);
        step(1);
        check("exec_wait_busy", 32'(busy), 32'd1);
        done(10'd168, 1'b0);
        check("show_168", 32'(disp_value), 32'd168);
        check("show_busy", 32'(busy), 32'd0);
        check("show_error", 32'(error), 32'd0);

        // chaining: 168 XOR 3
        opkey(OP_XOR);
        dig(4'd3);
        push(10'd168, 10'd3, OP_XOR);
        key(KEY_EQUALS, 4'd0);
        step(2);
        done(10'd171, 1'b0);
        check("chain_show", 32'(disp_value), 32'd171);
        key(KEY_CLEAR, 4'd0);
        check("clear_disp", 32'(disp_value), 32'd0);

        // 999 out of range at commit
        dig(4'd9); dig(4'd9); dig(4'd9);
        check("entry_999", 32'(disp_value), 32'd999);
        opkey(OP_ADD);
        check("range_999_error", 32'(error), 32'd1);
        check("err_disp", 32'(disp_value), 32'd0);
        dig(4'd1);
        check("err_sticky", 32'(error), 32'd1);
        key(KEY_CLEAR, 4'd0);
        check("clr_error", 32'(error), 32'd0);
        check("clr_disp", 32'(disp_value), 32'd0);

        // +512 rejected
        dig(4'd5); dig(4'd1); dig(4'd2);
        opkey(OP_ADD);
        check("range_p512_error", 32'(error), 32'd1);
        key(KEY_CLEAR, 4'd0);

        // -512 accepted, 4th digit dropped, then timeout
        dig(4'd5); dig(4'd1); dig(4'd2);
        key(KEY_SIGN, 4'd0);
        check("entry_m512", 32'(disp_value), 32'h200);
        opkey(OP_AND);
        check("m512_no_error", 32'(error), 32'd0);
        check("m512_alu_a", 32'(alu_a), 32'h200);
        dig(4'd1); dig(4'd2); dig(4'd3); dig(4'd4);
        check("fourth_digit_ignored", 32'(disp_value), 32'd123);
        push(10'h200, 10'd123, OP_AND);
        key(KEY_EQUALS, 4'd0);
        step(16);
        check("tmo_not_early", 32'(error), 32'd0);
        check("tmo_busy_16", 32'(busy), 32'd1);
        step(1);
        check("tmo_error_17", 32'(error), 32'd1);
        check("tmo_busy", 32'(busy), 32'd0);
        key(KEY_CLEAR, 4'd0);

        // +511 accepted, ALU reports error
        dig(4'd5); dig(4'd1); dig(4'd1);
        opkey(OP_OR);
        check("p511_alu_a", 32'(alu_a), 32'd511);
        check("p511_no_error", 32'(error), 32'd0);
        dig(4'd7);
        push(10'd511, 10'd7, OP_OR);
        key(KEY_EQUALS, 4'd0);
        step(1);
        done(10'd0, 1'b1);
        check("alu_error_flag", 32'(error), 32'd1);
        key(KEY_CLEAR, 4'd0);
        check("alu_error_cleared", 32'(error), 32'd0);

        // unary NOT executes straight from S_A
        dig(4'd7);
        push(10'd7, 10'd0, OP_NOT);
        opkey(OP_NOT);
        check("not_busy", 32'(busy), 32'd1);
        done(10'h3F8, 1'b0);
        check("not_show", 32'(disp_value), 32'h3F8);
        key(KEY_CLEAR, 4'd0);

        // CLEAR aborts exec, late done ignored
        dig(4'd2);
        opkey(OP_ADD);
        dig(4'd3);
        push(10'd2, 10'd3, OP_ADD);
        key(KEY_EQUALS, 4'd0);
        step(1);
        key(KEY_CLEAR, 4'd0);
        step(1);
        done(10'd77, 1'b0);
        check("late_done_disp", 32'(disp_value), 32'd0);
        check("late_done_busy", 32'(busy), 32'd0);
        check("late_done_error", 32'(error), 32'd0);
        dig(4'd6);
        check("after_abort_s_a", 32'(disp_value), 32'd6);

        // CLEAR and alu_done together: CLEAR wins
        opkey(OP_ADD);
        dig(4'd1);
        push(10'd6, 10'd1, OP_ADD);
        key(KEY_EQUALS, 4'd0);
        step(1);
        key_valid  = 1'b1;
        key_type   = KEY_CLEAR;
        alu_done   = 1'b1;
        alu_result = 10'd99;
        step(1);
        key_valid  = 1'b0;
        key_type   = 3'd0;
        alu_done   = 1'b0;
        alu_result = 10'd0;
        check("clear_beats_done_disp", 32'(disp_value), 32'd0);
        check("clear_beats_done_busy", 32'(busy), 32'd0);
        dig(4'd8);
        check("entry_8", 32'(disp_value), 32'd8);

        // key coincident with a stray alu_done is dropped
        key_valid = 1'b1;
        key_type  = KEY_DIGIT;
        key_val   = 4'd5;
        alu_done  = 1'b1;
        step(1);
        key_valid = 1'b0;
        key_val   = 4'd0;
        alu_done  = 1'b0;
        check("key_dropped_with_done", 32'(disp_value), 32'd8);

        step(3);
        check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
